l1d_evict_wb_buf: RTL and testbench

Eviction write-back buffer downstream of the L1D data-RAM evict read port. Captures evicted line beats (tag, index, offset, data, last, MSHR evict id) as the data RAM streams them out. Forwards them to the downstream write channel under credit-based flow control. Pulses a per-line completion back to the MSHR when the last beat of a line has been sent.

---
 rtl/l1d_evict_wb_buf.sv | 167 ++++++++++++++++
 tb/tb_l1d_evict_wb_buf.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1d_evict_wb_buf.sv
// L1D eviction write-back buffer: captures evicted line beats and forwards
// them downstream under credit flow control, signalling line completion.
module l1d_evict_wb_buf #(
    parameter int TAG_W      = 4,
    parameter int INDEX_W    = 4,
    parameter int OFFSET_W   = 2,
    parameter int DATA_W     = 64,
    parameter int ID_W       = 5,
    parameter int CREDIT_NUM = 4,
    parameter int BUF_DEPTH  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                evict_vld,
    output logic                evict_rdy,
    input  logic [TAG_W-1:0]    evict_tag,
    input  logic [INDEX_W-1:0]  evict_index,
    input  logic [OFFSET_W-1:0] evict_offset,
    input  logic [DATA_W-1:0]   evict_data,
    input  logic                evict_last,
    input  logic [ID_W-1:0]     evict_id,
    output logic                down_vld,
    output logic [TAG_W-1:0]    down_tag,
    output logic [INDEX_W-1:0]  down_index,
    output logic [OFFSET_W-1:0] down_offset,
    output logic [DATA_W-1:0]   down_data,
    output logic                down_last,
    input  logic                down_credit_ret,
    output logic                done_vld,
    output logic [ID_W-1:0]     done_id,
    output logic                busy,
    output logic                credit_err
);

    localparam int PW   = $clog2(BUF_DEPTH);
    localparam int CNTW = $clog2(BUF_DEPTH + 1);
    localparam int CRW  = $clog2(CREDIT_NUM + 1);
    localparam logic [CNTW-1:0]     FULL     = CNTW'(BUF_DEPTH);
    localparam logic [CRW-1:0]      CMAX     = CRW'(CREDIT_NUM);
    localparam logic [OFFSET_W-1:0] LAST_OFF = '1;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
        logic [DATA_W-1:0]   data;
        logic                last;
        logic [ID_W-1:0]     id;
    } beat_t;

    beat_t mem_q [BUF_DEPTH];
    beat_t in_beat;
    beat_t head;

    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]     count_q, count_d;
    logic [CRW-1:0]      credit_q, credit_d;
    logic [OFFSET_W-1:0] bcnt_q, bcnt_d;
    logic                cerr_q, cerr_d;

    logic                down_vld_q;
    logic [TAG_W-1:0]    down_tag_q;
    logic [INDEX_W-1:0]  down_index_q;
    logic [OFFSET_W-1:0] down_offset_q;
    logic [DATA_W-1:0]   down_data_q;
    logic                down_last_q;
    logic                done_vld_q;
    logic [ID_W-1:0]     done_id_q;

    logic push;
    logic pop;

    assign in_beat = '{tag:    evict_tag,
                       index:  evict_index,
                       offset: evict_offset,
                       data:   evict_data,
                       last:   evict_last,
                       id:     evict_id};
    assign head = mem_q[rd_ptr_q];

    // No bypass: a full FIFO stays not-ready even if it pops this cycle
    assign evict_rdy = !rst && (count_q != FULL);
    assign push      = evict_vld && evict_rdy;
    assign pop       = (count_q != '0) && (credit_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        credit_d = credit_q;
        cerr_d   = cerr_q;
        bcnt_d   = bcnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: ;
        endcase
        case ({pop, down_credit_ret})
            2'b10: credit_d = credit_q - CRW'(1);
            2'b01: begin
                if (credit_q == CMAX) cerr_d = 1'b1;
                else                  credit_d = credit_q + CRW'(1);
            end
            default: ;
        endcase
        // Line framing check: last must coincide with the final beat slot
        if (push) begin
            if (evict_last != (bcnt_q == LAST_OFF)) cerr_d = 1'b1;
            bcnt_d = evict_last ? '0 : bcnt_q + OFFSET_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_beat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            credit_q      <= CMAX;
            cerr_q        <= 1'b0;
            bcnt_q        <= '0;
            down_vld_q    <= 1'b0;
            down_tag_q    <= '0;
            down_index_q  <= '0;
            down_offset_q <= '0;
            down_data_q   <= '0;
            down_last_q   <= 1'b0;
            done_vld_q    <= 1'b0;
            done_id_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            cerr_q     <= cerr_d;
            bcnt_q     <= bcnt_d;
            down_vld_q <= pop;
            done_vld_q <= pop && head.last;
            if (pop) begin
                down_tag_q    <= head.tag;
                down_index_q  <= head.index;
                down_offset_q <= head.offset;
                down_data_q   <= head.data;
                down_last_q   <= head.last;
            end
            if (pop && head.last) done_id_q <= head.id;
        end
    end

    assign down_vld    = down_vld_q;
    assign down_tag    = down_tag_q;
    assign down_index  = down_index_q;
    assign down_offset = down_offset_q;
    assign down_data   = down_data_q;
    assign down_last   = down_last_q;
    assign done_vld    = done_vld_q;
    assign done_id     = done_id_q;
    assign credit_err  = cerr_q;
    assign busy        = (count_q != '0) || down_vld_q || (credit_q != CMAX);

endmodule

// File: tb/tb_l1d_evict_wb_buf.sv
// Bench for l1d_evict_wb_buf: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_l1d_evict_wb_buf;

    localparam int CN    = 4;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [3:0]  tag;
        logic [3:0]  index;
        logic [1:0]  offset;
        logic [63:0] data;
        logic        last;
        logic [4:0]  id;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        evict_vld = 1'b0;
    logic        evict_rdy;
    logic [3:0]  evict_tag = '0;
    logic [3:0]  evict_index = '0;
    logic [1:0]  evict_offset = '0;
    logic [63:0] evict_data = '0;
    logic        evict_last = 1'b0;
    logic [4:0]  evict_id = '0;
    logic        down_vld;
    logic [3:0]  down_tag;
    logic [3:0]  down_index;
    logic [1:0]  down_offset;
    logic [63:0] down_data;
    logic        down_last;
    logic        down_credit_ret = 1'b0;
    logic        done_vld;
    logic [4:0]  done_id;
    logic        busy;
    logic        credit_err;

    int checks = 0;
    int errors = 0;

    beat_t q[$];
    int    m_cred;
    bit    m_err;
    int    m_bcnt;
    bit    m_dvld;
    bit    m_done;
    bit    m_push;
    beat_t m_out;

    always #5 clk = ~clk;

    l1d_evict_wb_buf dut (
        .clk(clk), .rst(rst),
        .evict_vld(evict_vld), .evict_rdy(evict_rdy),
        .evict_tag(evict_tag), .evict_index(evict_index),
        .evict_offset(evict_offset), .evict_data(evict_data),
        .evict_last(evict_last), .evict_id(evict_id),
        .down_vld(down_vld), .down_tag(down_tag), .down_index(down_index),
        .down_offset(down_offset), .down_data(down_data),
        .down_last(down_last), .down_credit_ret(down_credit_ret),
        .done_vld(done_vld), .done_id(done_id),
        .busy(busy), .credit_err(credit_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input int off, input bit last, input int id);
        beat_t b;
        b.tag    = 4'($urandom);
        b.index  = 4'($urandom);
        b.offset = 2'(off);
        b.data   = {$urandom, $urandom};
        b.last   = last;
        b.id     = 5'(id);
        return b;
    endfunction

    task automatic model_reset();
        q.delete();
        m_cred = CN;
        m_err  = 1'b0;
        m_bcnt = 0;
        m_dvld = 1'b0;
        m_done = 1'b0;
    endtask

    // One clock of the reference: sends from the head of the queue while
    // credits remain, a beat enqueued this cycle is only visible next cycle.
    task automatic model_step(input bit v, input bit ret, input beat_t b);
        bit pop;
        pop    = (q.size() > 0) && (m_cred > 0);
        m_push = v && (q.size() < DEPTH);
        m_dvld = pop;
        m_done = 1'b0;
        if (pop) begin
            m_out  = q.pop_front();
            m_done = m_out.last;
        end
        if (m_push) begin
            if (b.last != (m_bcnt == 3)) m_err = 1'b1;
            m_bcnt = b.last ? 0 : (m_bcnt + 1) % 4;
            q.push_back(b);
        end
        if (pop && !ret) m_cred--;
        else if (ret && !pop) begin
            if (m_cred == CN) m_err = 1'b1;
            else m_cred++;
        end
    endtask

    task automatic check_outputs();
        chk("down_vld", 64'(down_vld), 64'(m_dvld));
        if (m_dvld) begin
            chk("down_tag", 64'(down_tag), 64'(m_out.tag));
            chk("down_index", 64'(down_index), 64'(m_out.index));
            chk("down_offset", 64'(down_offset), 64'(m_out.offset));
            chk("down_data", down_data, m_out.data);
            chk("down_last", 64'(down_last), 64'(m_out.last));
        end
        chk("done_vld", 64'(done_vld), 64'(m_done));
        if (m_done) chk("done_id", 64'(done_id), 64'(m_out.id));
        chk("evict_rdy", 64'(evict_rdy), 64'(q.size() != DEPTH));
        chk("busy", 64'(busy),
            64'((q.size() != 0) || m_dvld || (m_cred != CN)));
        chk("credit_err", 64'(credit_err), 64'(m_err));
    endtask

    task automatic cyc(input bit v, input bit ret, input beat_t b);
        evict_vld       = v;
        evict_tag       = b.tag;
        evict_index     = b.index;
        evict_offset    = b.offset;
        evict_data      = b.data;
        evict_last      = b.last;
        evict_id        = b.id;
        down_credit_ret = ret;
        model_step(v, ret, b);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0);
    endtask

    task automatic send(input beat_t b, input bit ret);
        int guard;
        guard = 0;
        cyc(1'b1, ret, b);
        while (!m_push) begin
            guard++;
            if (guard > 40) begin
                errors++;
                $display("FAIL push_timeout observed=stalled expected=accepted");
                return;
            end
            cyc(1'b1, 1'b0, b);
        end
    endtask

    task automatic send_line(input int id);
        for (int i = 0; i < 4; i++) send(mk(i, i == 3, id), 1'b0);
    endtask

    task automatic restore_credits();
        int guard;
        guard = 0;
        idle(2);
        while (m_cred < CN || q.size() != 0) begin
            guard++;
            if (guard > 40) begin
                errors++;
                $display("FAIL credit_restore_timeout observed=%0d expected=%0d",
                         m_cred, CN);
                return;
            end
            cyc(1'b0, m_cred < CN, '0);
        end
        idle(1);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        evict_vld       = 1'b0;
        down_credit_ret = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_evict_rdy", 64'(evict_rdy), 64'(0));
        chk("rst_down_vld", 64'(down_vld), 64'(0));
        chk("rst_down_data", down_data, 64'(0));
        chk("rst_done_vld", 64'(done_vld), 64'(0));
        chk("rst_done_id", 64'(done_id), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_credit_err", 64'(credit_err), 64'(0));
        rst = 1'b0;
        #1;
        chk("rel_evict_rdy", 64'(evict_rdy), 64'(1));
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();

        // single line, id 5, no credit returns
        send_line(5);
        idle(4);
        chk("line1_busy", 64'(busy), 64'(1));

        // four returns bring busy back down
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, '0);
        chk("line1_idle", 64'(busy), 64'(0));
        chk("line1_err", 64'(credit_err), 64'(0));

        // three lines back-to-back fill the FIFO
        send_line(1);
        send_line(2);
        send_line(3);
        chk("fill_rdy", 64'(evict_rdy), 64'(0));
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, '0);
        restore_credits();

        // pop and credit return together at one remaining credit
        for (int i = 0; i < 5; i++) send(mk(i % 4, i == 3, 9), i == 4);
        for (int i = 1; i < 4; i++) send(mk(i, i == 3, 10), 1'b0);
        restore_credits();

        // over-return while idle
        cyc(1'b0, 1'b1, '0);
        chk("over_ret_err", 64'(credit_err), 64'(1));
        idle(2);
        do_reset();

        // early last on offset 1
        send(mk(0, 1'b0, 4), 1'b0);
        send(mk(1, 1'b1, 4), 1'b0);
        chk("early_last_err", 64'(credit_err), 64'(1));
        idle(3);
        do_reset();

        // reset while six beats are buffered
        for (int i = 0; i < 10; i++) send(mk(i % 4, (i % 4) == 3, 7), 1'b0);
        idle(1);
        do_reset();
        idle(4);
        restore_credits();

        // random traffic, well-formed lines, no over-return
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom % 4) != 0, (m_cred < CN) && ($urandom % 3 == 0),
                mk(m_bcnt, m_bcnt == 3, int'($urandom % 32)));
        end
        restore_credits();
        do_reset();

        // random traffic with framing errors and over-returns
        for (int i = 0; i < 200; i++) begin
            cyc(($urandom % 3) != 0, $urandom % 3 == 0,
                mk(m_bcnt, (m_bcnt == 3) ^ ($urandom % 25 == 0),
                   int'($urandom % 32)));
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
